// File: rtl/par_bus_pkg.sv
// Shared types and elaboration helpers for the asynchronous parallel bus master.
// The FSM state enum and the phase counter width are derived here.
package par_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_e;

  function automatic int max_phase(input int setup_cyc, input int strobe_cyc,
                                   input int hold_cyc, input int turn_cyc);
    int m;
    m = setup_cyc;
    if (strobe_cyc > m) m = strobe_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (turn_cyc > m) m = turn_cyc;
    return m;
  endfunction

  // The counter holds phase length minus one, so clog2 of the longest phase suffices.
  function automatic int cnt_width(input int max_len);
    return (max_len <= 2) ? 1 : $clog2(max_len);
  endfunction

  function automatic bit params_ok(input int data_w, input int setup_cyc, input int strobe_cyc,
                                   input int hold_cyc, input int turn_cyc);
    return (data_w >= 1) && (setup_cyc >= 1) && (strobe_cyc >= 1) &&
           (hold_cyc >= 1) && (turn_cyc >= 0);
  endfunction

endpackage

// File: rtl/par_bus_master_if.sv
// Command/response handshake and pad-facing signals of the parallel bus master.
// The master modport is the sequencer's view; slave is the opposite side.
interface par_bus_master_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [DATA_W-1:0] d_out;
  logic [DATA_W-1:0] d_oe;
  logic [DATA_W-1:0] d_in;
  logic              cs_n;
  logic              wr_n;
  logic              rd_n;

  modport master (
    input  cmd_valid, cmd_write, cmd_wdata, d_in,
    output cmd_ready, rsp_valid, rsp_rdata, d_out, d_oe, cs_n, wr_n, rd_n
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_wdata, d_in,
    input  cmd_ready, rsp_valid, rsp_rdata, d_out, d_oe, cs_n, wr_n, rd_n
  );
endinterface

// File: rtl/par_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; done_o marks the last cycle of the phase.
module par_bus_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/par_bus_master.sv
// Single-transaction sequencer for an asynchronous parallel peripheral bus.
// Pad-facing outputs are registered from the next state so they switch with the FSM.
module par_bus_master
  import par_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic           CLK,
  input  logic           RST,
  par_bus_master_if.master bus
);

  localparam int MAX_LEN = max_phase(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);
  localparam int CNT_W   = cnt_width(MAX_LEN);

  if (!params_ok(DATA_W, SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC)) begin : g_bad_params
    $error("par_bus_master: parameter below its minimum");
  end

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic [DATA_W-1:0] d_oe_q, d_oe_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              bus_active;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_done;

  par_bus_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .done_o    (timer_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      d_out_q     <= '0;
      d_oe_q      <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    write_d     = write_q;
    d_out_d     = d_out_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    timer_val   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = SETUP;
          write_d = bus.cmd_write;
          if (bus.cmd_write) d_out_d = bus.cmd_wdata;
        end
      end
      SETUP: begin
        if (timer_done) state_d = STROBE;
      end
      STROBE: begin
        // Read data is taken on the edge that releases rd_n.
        if (timer_done) begin
          state_d = HOLD;
          if (!write_q) begin
            rsp_rdata_d = bus.d_in;
            rsp_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (timer_done) state_d = (!write_q && TURN_CYC > 0) ? TURN : IDLE;
      end
      TURN: begin
        if (timer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    timer_load = (state_d != state_q) && (state_d != IDLE);
    unique case (state_d)
      SETUP:   timer_val = CNT_W'(SETUP_CYC - 1);
      STROBE:  timer_val = CNT_W'(STROBE_CYC - 1);
      HOLD:    timer_val = CNT_W'(HOLD_CYC - 1);
      TURN:    timer_val = CNT_W'(TURN_CYC - 1);
      default: timer_val = '0;
    endcase

    bus_active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d     = !bus_active;
    wr_n_d     = !((state_d == STROBE) && write_d);
    rd_n_d     = !((state_d == STROBE) && !write_d);
    d_oe_d     = (bus_active && write_d) ? {DATA_W{1'b1}} : '0;
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.rd_n      = rd_n_q;

endmodule

// File: tb/tb_par_bus_master.sv
// Self-checking bench: directed waveform checks plus randomized traffic
// compared every cycle against a transaction-timeline model.
module tb_par_bus_master;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int B  = 4;
  localparam int H  = 1;
  localparam int TU = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  par_bus_master_if #(.DATA_W(DW)) bus ();

  par_bus_master #(
    .DATA_W    (DW),
    .SETUP_CYC (S),
    .STROBE_CYC(B),
    .HOLD_CYC  (H),
    .TURN_CYC  (TU)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline of cycles k=1..len after its accept edge.
  bit          m_busy  = 1'b0;
  int          m_k     = 0;
  bit          m_wr    = 1'b0;
  logic [DW-1:0] m_dout  = '0;
  logic [DW-1:0] m_rdata = '0;

  function automatic int txn_len(input bit wr);
    return S + B + H + (wr ? 0 : TU);
  endfunction

  initial forever begin
    bit active, strobe;
    @(posedge CLK);
    if (RST) begin
      m_busy = 1'b0; m_k = 0; m_wr = 1'b0; m_dout = '0; m_rdata = '0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_wr   = bus.cmd_write;
        if (m_wr) m_dout = bus.cmd_wdata;
      end
    end else begin
      if (!m_wr && m_k == S + B) m_rdata = bus.d_in;
      m_k++;
      if (m_k > txn_len(m_wr)) begin
        m_busy = 1'b0;
        m_k    = 0;
      end
    end
    #1;
    active = m_busy && (m_k <= S + B + H);
    strobe = m_busy && (m_k > S) && (m_k <= S + B);
    check("m_cmd_ready", bus.cmd_ready, !m_busy);
    check("m_cs_n", bus.cs_n, !active);
    check("m_wr_n", bus.wr_n, !(strobe && m_wr));
    check("m_rd_n", bus.rd_n, !(strobe && !m_wr));
    check("m_d_oe", bus.d_oe, (active && m_wr) ? {DW{1'b1}} : '0);
    check("m_d_out", bus.d_out, m_dout);
    check("m_rsp_valid", bus.rsp_valid, m_busy && !m_wr && (m_k == S + B + 1));
    check("m_rsp_rdata", bus.rsp_rdata, m_rdata);
    check("m_contention", (bus.d_oe != '0) && !bus.rd_n, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("wait_idle_timeout", bus.cmd_ready, 1'b1);
  endtask

  task automatic issue(input bit wr, input logic [DW-1:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_wdata = data;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.d_in      = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Idle after reset
    repeat (5) begin
      @(negedge CLK);
      check("idle_ready", bus.cmd_ready, 1);
      check("idle_cs_wr_rd", {bus.cs_n, bus.wr_n, bus.rd_n}, 3'b111);
      check("idle_d_oe", bus.d_oe, 8'h00);
      check("idle_rsp_valid", bus.rsp_valid, 0);
    end

    // Write 0xA5
    wait_idle();
    issue(1'b1, 8'hA5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c == 1) bus.cmd_valid = 1'b0;
      if (c <= 7) begin
        check("wr_cs_n", bus.cs_n, 0);
        check("wr_d_oe", bus.d_oe, 8'hFF);
        check("wr_d_out", bus.d_out, 8'hA5);
        check("wr_wr_n", bus.wr_n, (c >= 3 && c <= 6) ? 0 : 1);
        check("wr_busy", bus.cmd_ready, 0);
      end else begin
        check("wr_ready_end", bus.cmd_ready, 1);
        check("wr_cs_n_end", bus.cs_n, 1);
      end
    end

    // Read 0x3C
    wait_idle();
    bus.d_in = 8'h3C;
    issue(1'b0, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 1) bus.cmd_valid = 1'b0;
      check("rd_rd_n", bus.rd_n, (c >= 3 && c <= 6) ? 0 : 1);
      check("rd_d_oe", bus.d_oe, 8'h00);
      check("rd_cs_n", bus.cs_n, (c <= 7) ? 0 : 1);
      check("rd_rsp_valid", bus.rsp_valid, (c == 7) ? 1 : 0);
      if (c == 7) check("rd_rsp_rdata", bus.rsp_rdata, 8'h3C);
      check("rd_ready", bus.cmd_ready, (c == 9) ? 1 : 0);
    end

    // Read sampling the last strobe cycle only
    wait_idle();
    bus.d_in = 8'h11;
    issue(1'b0, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 1) bus.cmd_valid = 1'b0;
      if (c == 6) bus.d_in = 8'h77;
      if (c == 7) check("late_rsp_rdata", bus.rsp_rdata, 8'h77);
    end

    // Read then write back-to-back with cmd_valid held
    wait_idle();
    bus.d_in = 8'hC3;
    issue(1'b0, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 8'h5A;
      end
      if (c == 9) check("b2b_ready", bus.cmd_ready, 1);
      check("b2b_d_oe", bus.d_oe, (c == 10) ? 8'hFF : 8'h00);
      if (c == 10) begin
        check("b2b_d_out", bus.d_out, 8'h5A);
        bus.cmd_valid = 1'b0;
      end
    end

    // Async reset in cycle 4 of a write
    wait_idle();
    issue(1'b1, 8'h3F);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 1) bus.cmd_valid = 1'b0;
    end
    check("rst_pre_wr_n", bus.wr_n, 0);
    #2 RST = 1'b1;
    #1;
    check("rst_wr_n", bus.wr_n, 1);
    check("rst_cs_n", bus.cs_n, 1);
    check("rst_d_oe", bus.d_oe, 8'h00);
    check("rst_ready", bus.cmd_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      check("post_rst_ready", bus.cmd_ready, 1);
      check("post_rst_rsp_valid", bus.rsp_valid, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      bus.cmd_valid = ($urandom % 3) != 0;
      bus.cmd_write = $urandom_range(0, 1);
      bus.cmd_wdata = DW'($urandom);
      bus.d_in      = DW'($urandom);
      if (i == 200) begin
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
    end
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    repeat (12) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_bus_master.md
Name: par_bus_master

Overview:
- Transaction sequencer that drives a bank of DATA_W bidirectional pad cells for an asynchronous parallel peripheral bus.
- Accepts single read/write commands on a valid/ready interface.
- Generates registered data, output-enable and active-low strobe/chip-select timing.
- Samples returned read data and returns it on a one-cycle response pulse.
- Sits directly upstream of the pad cells: d_out/d_oe feed the pad output/enable pins, and d_in comes from the pad input pins.

Parameters:
DATA_W, 8, bus width in bits (>=1)
SETUP_CYC, 2, cycles cs_n/data/address phase precede strobe (>=1)
STROBE_CYC, 4, cycles wr_n or rd_n held low (>=1)
HOLD_CYC, 1, cycles after strobe release before cs_n/oe drop (>=1)
TURN_CYC, 1, idle cycles after every read before the next command is accepted (>=0; 0 = no TURN state)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command (high only in IDLE)
cmd_write  input  1  1=write, 0=read
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: read data valid
rsp_rdata  output  DATA_W  read data, stable until next read response
d_out  output  DATA_W  to pad output pins
d_oe  output  DATA_W  to pad enables, all bits equal
d_in  input  DATA_W  from pad input pins (unregistered pads)
cs_n  output  1  chip select, active low
wr_n  output  1  write strobe, active low
rd_n  output  1  read strobe, active low

Behaviour:
- Reset values: d_out=0, d_oe=0, cs_n=1, wr_n=1, rd_n=1, rsp_valid=0, rsp_rdata=0, state=IDLE; cmd_ready=1.
- Async reset forces these values immediately mid-transaction; pending transaction is dropped; no rsp_valid is issued.
- Handshake: transfer on rising edge where cmd_valid&&cmd_ready. cmd_write and cmd_wdata are captured on that edge; later changes are ignored.
- FSM states: IDLE, SETUP, STROBE, HOLD, TURN. One down-counter loaded on each phase entry with the phase length minus 1.
- IDLE -> SETUP on accept.
- SETUP -> STROBE after SETUP_CYC cycles.
- STROBE -> HOLD after STROBE_CYC cycles.
- HOLD -> TURN (read, TURN_CYC>0), else IDLE, after HOLD_CYC cycles.
- TURN -> IDLE after TURN_CYC cycles.
- All pad-facing outputs are registered and change on the same edge the state changes.
- cs_n=0 in SETUP, STROBE, HOLD.
- Write: d_oe=all-ones and d_out=captured data in SETUP, STROBE, HOLD; wr_n=0 in STROBE only.
- Read: d_oe=0 throughout; d_out unchanged; rd_n=0 in STROBE only.
- Read sample: d_in is captured into rsp_rdata on the edge leaving the last STROBE cycle; rsp_valid=1 for exactly the first HOLD cycle.
- Bus contention rule: d_oe!=0 and rd_n=0 never occur in the same cycle. After any read, d_oe stays 0 for at least HOLD_CYC+TURN_CYC+SETUP_CYC... no, d_oe stays 0 until the next write's SETUP, which is at least HOLD_CYC+TURN_CYC+1 cycles after rd_n rises.
- Write latency: accept to cmd_ready high = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 edges.
- Read latency: same plus TURN_CYC.
- Back-to-back: cmd_valid held high gives the next accept on the first IDLE cycle; no cycle is lost beyond the phases.
- Counter width: clog2 of the maximum phase length; no wrap, since it reloads on every phase entry.

Decomposition:
- Package par_bus_pkg: state enum (IDLE, SETUP, STROBE, HOLD, TURN), counter width function/constant, and elaboration checks for parameter minimums.
- Pad instances stay in the top level; this block contains none.
- Optional sub-module par_bus_phase_timer: loadable down-counter with a done flag.

Test Plan (defaults):
- Reset asserted, then released with cmd_valid=0 -> cs_n=wr_n=rd_n=1, d_oe=0x00, rsp_valid=0, cmd_ready=1 indefinitely.
- Write 0xA5 accepted at edge 0 -> cycles 1-7: cs_n=0, d_oe=0xFF, d_out=0xA5; wr_n=0 in cycles 3-6 only; cmd_ready=1 at cycle 8.
- Read, d_in=0x3C during cycles 3-6 -> rd_n=0 in cycles 3-6, d_oe=0x00 throughout; rsp_valid=1 in cycle 7 only with rsp_rdata=0x3C; TURN in cycle 8; cmd_ready=1 at cycle 9.
- Read immediately followed by write 0x5A (cmd_valid held) -> d_oe first 0xFF at cycle 10; no cycle has d_oe!=0 with rd_n=0.
- Read with d_in=0x11 in cycles 3-5 and 0x77 in cycle 6 -> rsp_rdata=0x77.
- RST pulsed during cycle 4 of a write -> wr_n=1, cs_n=1, d_oe=0 within the same cycle; after release, cmd_ready=1 and no rsp_valid.
